// File: rtl/opb_slave_pkg.sv
// Shared types and helpers for the OPB software-register slaves.
package opb_slave_pkg;

    // Transfer sequencing: accept, acknowledge, then one dead cycle.
    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StHold
    } ack_state_e;

    // Word indices within the slave window.
    localparam logic [5:0] DataWord = 6'd0;
    localparam logic [5:0] WcntWord = 6'd1;

    // OPB numbers bit 0 as the MSB; the user side numbers bit 31 as the MSB.
    function automatic logic [31:0] opb_to_user(input logic [0:31] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[31-i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Address decode, IDLE/ACK/HOLD sequencing and latched transfer fields for an OPB slave.
module opb_slave_ack_fsm
    import opb_slave_pkg::*;
#(
    parameter logic [31:0] BaseAddr = 32'h0100_4200,
    parameter logic [31:0] HighAddr = 32'h0100_42FF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        select_i,
    input  logic [0:31] abus_i,
    input  logic        rnw_i,
    input  logic [0:3]  be_i,
    input  logic [0:31] dbus_i,
    output logic        ack_o,
    output logic [5:0]  offset_o,
    output logic        rnw_o,
    output logic [0:3]  be_o,
    output logic [0:31] dbus_o
);

    ack_state_e  state_q, state_d;
    logic [5:0]  offset_q, offset_d;
    logic        rnw_q, rnw_d;
    logic [0:3]  be_q, be_d;
    logic [0:31] dbus_q, dbus_d;
    logic        hit;

    assign hit = select_i && (abus_i >= BaseAddr) && (abus_i <= HighAddr);

    // Next state and transfer-field capture.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        rnw_d    = rnw_q;
        be_d     = be_q;
        dbus_d   = dbus_q;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    offset_d = abus_i[24:29];
                    rnw_d    = rnw_i;
                    be_d     = be_i;
                    dbus_d   = dbus_i;
                    state_d  = StAck;
                end
            end
            StAck:   state_d = StHold;
            // Dead cycle so a select still held from the last beat cannot re-ack it.
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and latched-field registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            offset_q <= '0;
            rnw_q    <= 1'b0;
            be_q     <= '0;
            dbus_q   <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            rnw_q    <= rnw_d;
            be_q     <= be_d;
            dbus_q   <= dbus_d;
        end
    end

    // Reset overrides a pending ack so nothing is acknowledged that will not commit.
    assign ack_o    = (state_q == StAck) && !rst_i;
    assign offset_o = offset_q;
    assign rnw_o    = rnw_q;
    assign be_o     = be_q;
    assign dbus_o   = dbus_q;

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// PPC-to-fabric software register: byte-writable data word plus a write-counter word.
module opb_register_ppc2simulink
    import opb_slave_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_4200,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_42FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5",
    parameter logic [31:0] C_INIT_VALUE = 32'h0000_0000
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    Sl_xferAck,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [31:0]             user_data_out,
    output logic                    user_data_valid
);

    logic        ack;
    logic [5:0]  offset;
    logic        rnw;
    logic [0:3]  be;
    logic [0:31] wdata;

    logic [0:31] data_q, data_d;
    logic [31:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        unused_seq_addr;

    // Every beat is a single transfer, so the burst hint carries no information.
    assign unused_seq_addr = OPB_seqAddr;

    opb_slave_ack_fsm #(
        .BaseAddr (C_BASEADDR),
        .HighAddr (C_HIGHADDR)
    ) u_ack_fsm (
        .clk_i    (OPB_Clk),
        .rst_i    (OPB_Rst),
        .select_i (OPB_select),
        .abus_i   (OPB_ABus),
        .rnw_i    (OPB_RNW),
        .be_i     (OPB_BE),
        .dbus_i   (OPB_DBus),
        .ack_o    (ack),
        .offset_o (offset),
        .rnw_o    (rnw),
        .be_o     (be),
        .dbus_o   (wdata)
    );

    // Write commit: byte merge into the data word, counter bump or clear.
    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (ack && !rnw) begin
            if (offset == DataWord) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        data_d[8*b +: 8] = wdata[8*b +: 8];
                    end
                end
                cnt_d   = cnt_q + 32'd1;
                valid_d = 1'b1;
            end else if (offset == WcntWord) begin
                cnt_d = '0;
            end
        end
    end

    // Register file with synchronous reset; reset also blocks a commit in flight.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_q  <= C_INIT_VALUE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Read mux; bus is driven to zero outside the ack cycle for the OR-bus.
    always_comb begin
        Sl_DBus = '0;
        if (ack && rnw) begin
            if (offset == DataWord) begin
                Sl_DBus = data_q;
            end else if (offset == WcntWord) begin
                Sl_DBus = cnt_q;
            end
        end
    end

    assign Sl_xferAck      = ack;
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;
    assign user_data_out   = opb_to_user(data_q);
    assign user_data_valid = valid_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Directed bench for opb_register_ppc2simulink.
module tb_opb_register_ppc2simulink;

    localparam logic [31:0] Base = 32'h0100_4200;
    localparam logic [31:0] Init = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic [0:31] sl_dbus;
    logic        sl_err_ack, sl_retry, sl_tout_sup, sl_xfer_ack;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw;
    logic        sel;
    logic        seq_addr;
    logic [31:0] uout;
    logic        uvalid;

    int checks = 0;
    int fails  = 0;

    logic        ack_n, ack_n1, ack_n2, valid_n2;
    logic [31:0] rd, uout_n2;

    opb_register_ppc2simulink #(
        .C_BASEADDR   (Base),
        .C_HIGHADDR   (32'h0100_42FF),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_FAMILY     ("virtex5"),
        .C_INIT_VALUE (Init)
    ) dut (
        .OPB_Clk         (clk),
        .OPB_Rst         (rst),
        .Sl_DBus         (sl_dbus),
        .Sl_errAck       (sl_err_ack),
        .Sl_retry        (sl_retry),
        .Sl_toutSup      (sl_tout_sup),
        .Sl_xferAck      (sl_xfer_ack),
        .OPB_ABus        (abus),
        .OPB_BE          (be),
        .OPB_DBus        (dbus),
        .OPB_RNW         (rnw),
        .OPB_select      (sel),
        .OPB_seqAddr     (seq_addr),
        .user_data_out   (uout),
        .user_data_valid (uvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        sel  = 1'b0;
        rnw  = 1'b0;
        abus = '0;
        be   = '0;
        dbus = '0;
    endtask

    // One-cycle select at cycle n; returns acks at n, n+1, n+2, read data at n+1 and
    // user outputs at n+2. Leaves time at cycle n+3, when the slave can accept again.
    task automatic xfer(input logic [31:0] addr, input logic r, input logic [31:0] wd,
                        input logic [3:0] b);
        abus = addr;
        rnw  = r;
        dbus = wd;
        be   = b;
        sel  = 1'b1;
        @(negedge clk);
        ack_n = sl_xfer_ack;
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        ack_n1 = sl_xfer_ack;
        rd     = sl_dbus;
        @(posedge clk); #1;
        ack_n2   = sl_xfer_ack;
        valid_n2 = uvalid;
        uout_n2  = uout;
        @(posedge clk); #1;
    endtask

    initial begin
        seq_addr = 1'b0;
        idle_bus();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_uout", uout, Init);
        check("rst_valid", {31'b0, uvalid}, 32'd0);
        check("rst_ack", {31'b0, sl_xfer_ack}, 32'd0);
        check("rst_dbus", sl_dbus, 32'd0);
        check("tied_sigs", {29'b0, sl_err_ack, sl_retry, sl_tout_sup}, 32'd0);
        xfer(Base + 32'h4, 1'b1, 32'h0, 4'h0);
        check("rst_cnt_ack", {31'b0, ack_n1}, 32'd1);
        check("rst_cnt", rd, 32'd0);

        // Full write and latency.
        xfer(Base, 1'b0, 32'h1234_5678, 4'b1111);
        check("wr_ack_n", {31'b0, ack_n}, 32'd0);
        check("wr_ack_n1", {31'b0, ack_n1}, 32'd1);
        check("wr_ack_n2", {31'b0, ack_n2}, 32'd0);
        check("wr_dbus_n1", rd, 32'd0);
        check("wr_uout", uout_n2, 32'h1234_5678);
        check("wr_valid", {31'b0, valid_n2}, 32'd1);
        check("wr_valid_n3", {31'b0, uvalid}, 32'd0);
        xfer(Base, 1'b1, 32'h0, 4'h0);
        check("rd_w0", rd, 32'h1234_5678);
        xfer(Base + 32'h4, 1'b1, 32'h0, 4'h0);
        check("rd_cnt1", rd, 32'd1);

        // Partial and empty byte enables.
        xfer(Base, 1'b0, 32'hAABB_CCDD, 4'b0101);
        check("be0101_uout", uout_n2, 32'h12BB_56DD);
        check("be0101_valid", {31'b0, valid_n2}, 32'd1);
        xfer(Base, 1'b0, 32'hFFFF_FFFF, 4'b0000);
        check("be0000_uout", uout_n2, 32'h12BB_56DD);
        check("be0000_valid", {31'b0, valid_n2}, 32'd1);
        check("be0000_ack", {31'b0, ack_n1}, 32'd1);
        xfer(Base + 32'h4, 1'b1, 32'h0, 4'h0);
        check("rd_cnt3", rd, 32'd3);

        // Unmapped words: read zero, writes acked and ignored.
        xfer(Base + 32'h8, 1'b1, 32'h0, 4'h0);
        check("rd_w2_ack", {31'b0, ack_n1}, 32'd1);
        check("rd_w2", rd, 32'd0);
        xfer(Base + 32'h14, 1'b0, 32'h0BAD_F00D, 4'b1111);
        check("wr_w5_ack", {31'b0, ack_n1}, 32'd1);
        check("wr_w5_uout", uout_n2, 32'h12BB_56DD);
        check("wr_w5_valid", {31'b0, valid_n2}, 32'd0);
        xfer(Base + 32'h4, 1'b1, 32'h0, 4'h0);
        check("rd_cnt3b", rd, 32'd3);

        // Counter clear.
        xfer(Base + 32'h4, 1'b0, 32'h1234_0000, 4'b1111);
        check("clr_valid", {31'b0, valid_n2}, 32'd0);
        xfer(Base + 32'h4, 1'b1, 32'h0, 4'h0);
        check("clr_cnt", rd, 32'd0);

        // Select held for six cycles on one read: acks at +1 and +4 only.
        abus = Base;
        rnw  = 1'b1;
        sel  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("hold_ack%0d", i), {31'b0, sl_xfer_ack},
                  (i == 1 || i == 4) ? 32'd1 : 32'd0);
            check($sformatf("hold_dbus%0d", i), sl_dbus,
                  (i == 1 || i == 4) ? 32'h12BB_56DD : 32'd0);
            @(posedge clk); #1;
            if (i == 5) idle_bus();
        end

        // Outside the window: no ack, no state change.
        xfer(Base + 32'h100, 1'b0, 32'h5A5A_5A5A, 4'b1111);
        check("oow_wr_ack", {31'b0, ack_n | ack_n1 | ack_n2}, 32'd0);
        check("oow_wr_uout", uout_n2, 32'h12BB_56DD);
        xfer(Base - 32'h4, 1'b1, 32'h0, 4'h0);
        check("oow_rd_ack", {31'b0, ack_n | ack_n1 | ack_n2}, 32'd0);
        check("oow_rd_dbus", rd, 32'd0);
        xfer(Base + 32'h4, 1'b1, 32'h0, 4'h0);
        check("oow_cnt", rd, 32'd0);

        // Reset sampled in the ACK cycle of a write: no commit.
        abus = Base;
        rnw  = 1'b0;
        dbus = 32'h5555_5555;
        be   = 4'b1111;
        sel  = 1'b1;
        @(posedge clk); #1;
        idle_bus();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ack", {31'b0, sl_xfer_ack}, 32'd0);
        check("mid_rst_dbus", sl_dbus, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_uout", uout, Init);
        check("mid_rst_valid", {31'b0, uvalid}, 32'd0);
        // Immediate acceptance shows the FSM is back in IDLE.
        xfer(Base, 1'b1, 32'h0, 4'h0);
        check("post_rst_ack", {31'b0, ack_n1}, 32'd1);
        check("post_rst_rd", rd, Init);
        xfer(Base + 32'h4, 1'b1, 32'h0, 4'h0);
        check("post_rst_cnt", rd, 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

endmodule
